// File: rtl/mcpu_seq_pkg.sv
// Shared definitions for the MCPU sequencer: opcodes, register-file commands,
// ALU commands, FSM states and the execute-stage data source selector.
package mcpu_seq_pkg;

  localparam logic [3:0] OPC_NOP = 4'b0000;
  localparam logic [3:0] OPC_LDI = 4'b0001;
  localparam logic [3:0] OPC_LD  = 4'b0010;
  localparam logic [3:0] OPC_ST  = 4'b0011;
  localparam logic [3:0] OPC_MOV = 4'b1000;
  localparam logic [3:0] OPC_JMP = 4'b1001;
  localparam logic [3:0] OPC_JC  = 4'b1010;
  localparam logic [3:0] OPC_HLT = 4'b1111;

  // Opcodes 01xx are ALU operations; the low two bits become the ALU command.
  localparam logic [1:0] OPC_ALU_PREFIX = 2'b01;

  localparam logic [1:0] REGSET_LOAD_MEM  = 2'b00;
  localparam logic [1:0] REGSET_MOV       = 2'b01;
  localparam logic [1:0] REGSET_LOAD_DATA = 2'b10;
  localparam logic [1:0] REGSET_STORE     = 2'b11;

  localparam logic [1:0] ALU_XOR = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b11;

  typedef enum logic [2:0] {
    ST_F0   = 3'd0,
    ST_F1   = 3'd1,
    ST_EX   = 3'd2,
    ST_WB   = 3'd3,
    ST_HALT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SRC_IMM = 2'd0,
    SRC_MEM = 2'd1,
    SRC_ALU = 2'd2,
    SRC_REG = 2'd3
  } datasrc_e;

endpackage

// File: rtl/mcpu_seq_decode.sv
// Combinational instruction decoder for the MCPU sequencer.
// MCPU_SEQ_BRANCH_EN enables decoding of the conditional jump JC.
module mcpu_seq_decode
  import mcpu_seq_pkg::*;
#(
  parameter int WORD_SIZE    = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int OPERAND_SIZE = 4
) (
  input  logic [WORD_SIZE-1:0]    ir_hi_i,
  input  logic [WORD_SIZE-1:0]    ir_lo_i,
  output logic [OPERAND_SIZE-1:0] op1_o,
  output logic [OPERAND_SIZE-1:0] op2_o,
  output logic [OPERAND_SIZE-1:0] op3_o,
  output logic [1:0]              regsetcmd_o,
  output logic [1:0]              alucmd_o,
  output logic [ADDR_WIDTH-1:0]   target_o,
  output datasrc_e                dataSrc_o,
  output logic                    isLoad_o,
  output logic                    isStore_o,
  output logic                    writesReg_o,
  output logic                    isJump_o,
  output logic                    isCondJump_o,
  output logic                    isHalt_o
);

  logic [3:0]              opcode;
  logic [OPERAND_SIZE-1:0] r1;
  logic [OPERAND_SIZE-1:0] r2;
  logic [OPERAND_SIZE-1:0] r3;

  assign opcode   = ir_hi_i[WORD_SIZE-1 -: 4];
  assign r1       = ir_hi_i[OPERAND_SIZE-1:0];
  assign r2       = ir_lo_i[WORD_SIZE-1 -: OPERAND_SIZE];
  assign r3       = ir_lo_i[OPERAND_SIZE-1:0];
  assign target_o = ir_lo_i[ADDR_WIDTH-1:0];

  always_comb begin
    op1_o        = '0;
    op2_o        = '0;
    op3_o        = '0;
    regsetcmd_o  = REGSET_LOAD_MEM;
    alucmd_o     = 2'b00;
    dataSrc_o    = SRC_IMM;
    isLoad_o     = 1'b0;
    isStore_o    = 1'b0;
    writesReg_o  = 1'b0;
    isJump_o     = 1'b0;
    isCondJump_o = 1'b0;
    isHalt_o     = 1'b0;
    if (opcode[3:2] == OPC_ALU_PREFIX) begin
      op1_o       = r1;
      op2_o       = r2;
      op3_o       = r3;
      alucmd_o    = opcode[1:0];
      dataSrc_o   = SRC_ALU;
      writesReg_o = 1'b1;
    end else begin
      case (opcode)
        OPC_LDI: begin
          op1_o       = r1;
          regsetcmd_o = REGSET_LOAD_DATA;
          writesReg_o = 1'b1;
        end
        OPC_LD: begin
          op1_o       = r1;
          dataSrc_o   = SRC_MEM;
          isLoad_o    = 1'b1;
          writesReg_o = 1'b1;
        end
        OPC_ST: begin
          op1_o       = r1;
          regsetcmd_o = REGSET_STORE;
          isStore_o   = 1'b1;
        end
        // The register file performs the copy from op2 itself; datatoload mirrors RegOp1.
        OPC_MOV: begin
          op1_o       = r1;
          op2_o       = r2;
          regsetcmd_o = REGSET_MOV;
          dataSrc_o   = SRC_REG;
          writesReg_o = 1'b1;
        end
        OPC_JMP: isJump_o = 1'b1;
`ifdef MCPU_SEQ_BRANCH_EN
        OPC_JC:  isCondJump_o = 1'b1;
`endif
        OPC_HLT: isHalt_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mcpu_sequencer.sv
// MCPU fetch/decode/execute sequencer: two-byte fetch, execute, optional write-back.
// MCPU_SEQ_BRANCH_EN makes JC jump when alu_cf is set; otherwise JC behaves as NOP.
module mcpu_sequencer
  import mcpu_seq_pkg::*;
#(
  parameter int WORD_SIZE    = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int OPERAND_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  output logic [ADDR_WIDTH-1:0]   instraddr,
  input  logic [WORD_SIZE-1:0]    instrrd,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic                    we,
  output logic                    re,
  output logic [WORD_SIZE-1:0]    datawr,
  input  logic [WORD_SIZE-1:0]    datard,
  output logic [OPERAND_SIZE-1:0] op1,
  output logic [OPERAND_SIZE-1:0] op2,
  output logic [OPERAND_SIZE-1:0] op3,
  output logic [1:0]              regsetcmd,
  output logic                    regsetwb,
  output logic [WORD_SIZE-1:0]    datatoload,
  input  logic [WORD_SIZE-1:0]    RegOp1,
  output logic [1:0]              alucmd,
  input  logic [WORD_SIZE-1:0]    alu_out,
  input  logic                    alu_cf,
  output logic                    halted
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [WORD_SIZE-1:0]    irHi_q, irHi_d;
  logic [WORD_SIZE-1:0]    irLo_q, irLo_d;
  logic [WORD_SIZE-1:0]    data_q, data_d;

  logic [OPERAND_SIZE-1:0] decOp1, decOp2, decOp3;
  logic [1:0]              decRegsetcmd, decAlucmd;
  logic [ADDR_WIDTH-1:0]   target;
  datasrc_e                dataSrc;
  logic                    isLoad, isStore, writesReg, isJump, isCondJump, isHalt;
  logic                    inEx, inWb, inInstr, taken;
  logic [WORD_SIZE-1:0]    loadMux;

  mcpu_seq_decode #(
    .WORD_SIZE    (WORD_SIZE),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .OPERAND_SIZE (OPERAND_SIZE)
  ) u_decode (
    .ir_hi_i      (irHi_q),
    .ir_lo_i      (irLo_q),
    .op1_o        (decOp1),
    .op2_o        (decOp2),
    .op3_o        (decOp3),
    .regsetcmd_o  (decRegsetcmd),
    .alucmd_o     (decAlucmd),
    .target_o     (target),
    .dataSrc_o    (dataSrc),
    .isLoad_o     (isLoad),
    .isStore_o    (isStore),
    .writesReg_o  (writesReg),
    .isJump_o     (isJump),
    .isCondJump_o (isCondJump),
    .isHalt_o     (isHalt)
  );

`ifdef MCPU_SEQ_BRANCH_EN
  assign taken = isJump | (isCondJump & alu_cf);
`else
  logic [1:0] unusedBranch;
  assign unusedBranch = {isCondJump, alu_cf};
  assign taken        = isJump;
`endif

  always_comb begin
    case (dataSrc)
      SRC_MEM: loadMux = datard;
      SRC_ALU: loadMux = alu_out;
      SRC_REG: loadMux = RegOp1;
      default: loadMux = irLo_q;
    endcase
  end

  // Control fields are only presented during EX and WB so they stay stable across both.
  assign inEx      = (state_q == ST_EX);
  assign inWb      = (state_q == ST_WB);
  assign inInstr   = inEx | inWb;
  assign instraddr = pc_q;
  assign op1       = inInstr ? decOp1 : '0;
  assign op2       = inInstr ? decOp2 : '0;
  assign op3       = inInstr ? decOp3 : '0;
  assign regsetcmd = inInstr ? decRegsetcmd : REGSET_LOAD_MEM;
  assign alucmd    = inInstr ? decAlucmd : 2'b00;
  assign addr      = (inInstr && (isLoad || isStore)) ? target : '0;
  assign re        = inEx & isLoad;
  assign we        = inWb & isStore;
  assign regsetwb  = inWb & writesReg;
  assign datawr    = we ? RegOp1 : '0;
  assign datatoload = !writesReg ? '0 : (inEx ? loadMux : (inWb ? data_q : '0));
  assign halted    = (state_q == ST_HALT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    irHi_d  = irHi_q;
    irLo_d  = irLo_q;
    data_d  = data_q;
    case (state_q)
      ST_F0: begin
        if (run) begin
          irHi_d  = instrrd;
          pc_d    = pc_q + 1'b1;
          state_d = ST_F1;
        end
      end
      ST_F1: begin
        irLo_d  = instrrd;
        pc_d    = pc_q + 1'b1;
        state_d = ST_EX;
      end
      ST_EX: begin
        if (writesReg) data_d = loadMux;
        if (isHalt) begin
          state_d = ST_HALT;
        end else if (writesReg || isStore) begin
          state_d = ST_WB;
        end else begin
          if (taken) pc_d = target;
          state_d = ST_F0;
        end
      end
      ST_WB:   state_d = ST_F0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_F0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_F0;
      pc_q    <= '0;
      irHi_q  <= '0;
      irLo_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      irHi_q  <= irHi_d;
      irLo_q  <= irLo_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_mcpu_sequencer.sv
// Self-checking bench for mcpu_sequencer with behavioural RAM, register file and ALU.
// A per-cycle vector table covers the first program; hand sequences cover the rest.
module tb_mcpu_sequencer;
  import mcpu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] instraddr, instrrd, addr, datawr, datard, datatoload, RegOp1, alu_out;
  logic       we, re, regsetwb, alu_cf, halted;
  logic [3:0] op1, op2, op3;
  logic [1:0] regsetcmd, alucmd;

  logic [7:0] ram  [256];
  logic [7:0] regs [16];
  logic       cfReg;
  logic [8:0] aluSum;
  int         weCount, wbCount, reCount;
  int         compared, mismatched;

  always #5 clk = ~clk;

  mcpu_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .instraddr  (instraddr),
    .instrrd    (instrrd),
    .addr       (addr),
    .we         (we),
    .re         (re),
    .datawr     (datawr),
    .datard     (datard),
    .op1        (op1),
    .op2        (op2),
    .op3        (op3),
    .regsetcmd  (regsetcmd),
    .regsetwb   (regsetwb),
    .datatoload (datatoload),
    .RegOp1     (RegOp1),
    .alucmd     (alucmd),
    .alu_out    (alu_out),
    .alu_cf     (alu_cf),
    .halted     (halted)
  );

  assign instrrd = ram[instraddr];
  assign datard  = ram[addr];
  assign RegOp1  = regs[op1];
  assign aluSum  = {1'b0, regs[op2]} + {1'b0, regs[op3]};
  assign alu_cf  = cfReg;

  always_comb begin
    case (alucmd)
      ALU_ADD: alu_out = aluSum[7:0];
      ALU_XOR: alu_out = regs[op2] ^ regs[op3];
      2'b01:   alu_out = regs[op2] | regs[op3];
      default: alu_out = regs[op2] & regs[op3];
    endcase
  end

  // Environment: RAM writes, register-file writes, carry flag and strobe counters.
  always @(posedge clk) begin
    if (we) begin
      ram[addr] <= datawr;
      weCount   <= weCount + 1;
    end
    if (re) reCount <= reCount + 1;
    if (regsetwb) begin
      wbCount <= wbCount + 1;
      case (regsetcmd)
        REGSET_MOV:   regs[op1] <= regs[op2];
        REGSET_STORE: ;
        default:      regs[op1] <= datatoload;
      endcase
      if (alucmd == ALU_ADD) cfReg <= aluSum[8];
    end
  end

  typedef struct {
    logic       run;
    logic [7:0] pc;
    logic       re, we, wb;
    logic [3:0] op1;
    logic [1:0] cmd;
    logic [7:0] addr, load, wr;
    logic       halt;
  } vec_t;

  vec_t vecs [24];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstVal, input logic runVal);
    reset = rstVal;
    run   = runVal;
  endtask

  task automatic clearEnv();
    for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
    cfReg <= 1'b0;
  endtask

  task automatic poke(input int a, input logic [7:0] b0, input logic [7:0] b1);
    ram[a]           <= b0;
    ram[(a + 1) % 256] <= b1;
  endtask

  // Leaves the bench just after a falling edge with reset released and the DUT in F0.
  task automatic resetDut(input logic runVal);
    @(negedge clk);
    applyStimulus(1'b1, runVal);
    @(negedge clk);
    applyStimulus(1'b0, runVal);
    weCount <= 0;
    wbCount <= 0;
    reCount <= 0;
  endtask

  task automatic waitHalted(input int budget, output int n);
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("haltReached", {31'd0, halted}, 32'd1);
  endtask

  task automatic loadProg1();
    clearEnv();
    poke(8'h00, 8'h10, 8'd46);
    poke(8'h02, 8'h11, 8'd54);
    poke(8'h04, 8'h30, 8'd100);
    poke(8'h06, 8'h31, 8'd101);
    poke(8'h08, 8'hF0, 8'h00);
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    compared   = 0;
    mismatched = 0;
    weCount    = 0;
    wbCount    = 0;
    reCount    = 0;
    applyStimulus(1'b1, 1'b0);

    //         run  pc     re  we  wb  op1   cmd    addr    load   wr     halt
    vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0,   8'd0,  8'd0,  1'b0};
    vecs[1]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0,   8'd0,  8'd0,  1'b0};
    vecs[2]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 4'd0, 2'd2, 8'd0,   8'd46, 8'd0,  1'b0};
    vecs[3]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 4'd0, 2'd2, 8'd0,   8'd46, 8'd0,  1'b0};
    vecs[4]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0,   8'd0,  8'd0,  1'b0};
    vecs[5]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0,   8'd0,  8'd0,  1'b0};
    vecs[6]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 4'd1, 2'd2, 8'd0,   8'd54, 8'd0,  1'b0};
    vecs[7]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 4'd1, 2'd2, 8'd0,   8'd54, 8'd0,  1'b0};
    vecs[8]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0,   8'd0,  8'd0,  1'b0};
    vecs[9]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0,   8'd0,  8'd0,  1'b0};
    vecs[10] = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 4'd0, 2'd3, 8'd100, 8'd0,  8'd0,  1'b0};
    vecs[11] = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 4'd0, 2'd3, 8'd100, 8'd0,  8'd46, 1'b0};
    vecs[12] = '{1'b0, 8'h06, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0,   8'd0,  8'd0,  1'b0};
    vecs[13] = '{1'b0, 8'h06, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0,   8'd0,  8'd0,  1'b0};
    vecs[14] = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0,   8'd0,  8'd0,  1'b0};
    vecs[15] = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0,   8'd0,  8'd0,  1'b0};
    vecs[16] = '{1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 4'd1, 2'd3, 8'd101, 8'd0,  8'd0,  1'b0};
    vecs[17] = '{1'b0, 8'h08, 1'b0, 1'b1, 1'b0, 4'd1, 2'd3, 8'd101, 8'd0,  8'd54, 1'b0};
    vecs[18] = '{1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0,   8'd0,  8'd0,  1'b0};
    vecs[19] = '{1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0,   8'd0,  8'd0,  1'b0};
    vecs[20] = '{1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0,   8'd0,  8'd0,  1'b0};
    vecs[21] = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0,   8'd0,  8'd0,  1'b0};
    vecs[22] = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0,   8'd0,  8'd0,  1'b1};
    vecs[23] = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0,   8'd0,  8'd0,  1'b1};

    // Program 1: LDI/LDI/ST/ST/HLT with a stall in F0 and run dropped during EX.
    loadProg1();
    resetDut(1'b1);
    for (int i = 0; i < 24; i++) begin
      checkOutput($sformatf("v%0d_pc", i),   {24'd0, instraddr},  {24'd0, vecs[i].pc});
      checkOutput($sformatf("v%0d_re", i),   {31'd0, re},         {31'd0, vecs[i].re});
      checkOutput($sformatf("v%0d_we", i),   {31'd0, we},         {31'd0, vecs[i].we});
      checkOutput($sformatf("v%0d_wb", i),   {31'd0, regsetwb},   {31'd0, vecs[i].wb});
      checkOutput($sformatf("v%0d_op1", i),  {28'd0, op1},        {28'd0, vecs[i].op1});
      checkOutput($sformatf("v%0d_cmd", i),  {30'd0, regsetcmd},  {30'd0, vecs[i].cmd});
      checkOutput($sformatf("v%0d_addr", i), {24'd0, addr},       {24'd0, vecs[i].addr});
      checkOutput($sformatf("v%0d_load", i), {24'd0, datatoload}, {24'd0, vecs[i].load});
      checkOutput($sformatf("v%0d_wr", i),   {24'd0, datawr},     {24'd0, vecs[i].wr});
      checkOutput($sformatf("v%0d_halt", i), {31'd0, halted},     {31'd0, vecs[i].halt});
      applyStimulus(1'b0, vecs[i].run);
      @(negedge clk);
    end
    checkOutput("p1_ram100", {24'd0, ram[100]}, 32'd46);
    checkOutput("p1_ram101", {24'd0, ram[101]}, 32'd54);
    checkOutput("p1_weCount", weCount, 32'd2);
    checkOutput("p1_wbCount", wbCount, 32'd2);
    checkOutput("p1_reCount", reCount, 32'd0);

    // Reset during EX of a store, then hold run low after release.
    loadProg1();
    resetDut(1'b1);
    repeat (10) @(negedge clk);
    checkOutput("rst_preEx_addr", {24'd0, addr}, 32'd100);
    applyStimulus(1'b1, 1'b1);
    weCount <= 0;
    wbCount <= 0;
    reCount <= 0;
    @(negedge clk);
    checkOutput("rst_we", {31'd0, we}, 32'd0);
    checkOutput("rst_wb", {31'd0, regsetwb}, 32'd0);
    checkOutput("rst_pc", {24'd0, instraddr}, 32'd0);
    applyStimulus(1'b0, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("stall_pc", {24'd0, instraddr}, 32'd0);
    checkOutput("stall_we", weCount, 32'd0);
    checkOutput("stall_wb", wbCount, 32'd0);
    checkOutput("stall_re", reCount, 32'd0);
    checkOutput("stall_ram100", {24'd0, ram[100]}, 32'd0);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("resume_pc", {24'd0, instraddr}, 32'd1);

    // Program 2: loads, ADD, XOR, MOV and stores.
    clearEnv();
    poke(8'h00, 8'h22, 8'd100);
    poke(8'h02, 8'h23, 8'd101);
    poke(8'h04, 8'h74, 8'h23);
    poke(8'h06, 8'h34, 8'd102);
    poke(8'h08, 8'h65, 8'h23);
    poke(8'h0A, 8'h35, 8'd103);
    poke(8'h0C, 8'h87, 8'h20);
    poke(8'h0E, 8'h37, 8'd104);
    poke(8'h10, 8'hF0, 8'h00);
    poke(100, 8'd46, 8'd54);
    resetDut(1'b1);
    waitHalted(200, n);
    checkOutput("p2_haltCycles", n, 32'd35);
    checkOutput("p2_ram102_add", {24'd0, ram[102]}, 32'd100);
    checkOutput("p2_ram103_xor", {24'd0, ram[103]}, 32'd24);
    checkOutput("p2_ram104_mov", {24'd0, ram[104]}, 32'd46);
    checkOutput("p2_r4", {24'd0, regs[4]}, 32'd100);
    checkOutput("p2_weCount", weCount, 32'd3);
    checkOutput("p2_wbCount", wbCount, 32'd5);
    checkOutput("p2_reCount", reCount, 32'd2);

    // Program 3: JMP 0xFE, LDI straddling the PC wrap, HLT fetched from 0x00.
    clearEnv();
    poke(8'h00, 8'h90, 8'hFE);
    poke(8'hFE, 8'h16, 8'd7);
    resetDut(1'b1);
    n = 0;
    while (instraddr !== 8'hFE && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("jmp_latency", n, 32'd3);
    poke(8'h00, 8'hF0, 8'h00);
    repeat (2) @(negedge clk);
    checkOutput("pc_wrap", {24'd0, instraddr}, 32'd0);
    waitHalted(50, n);
    checkOutput("p3_haltPc", {24'd0, instraddr}, 32'd2);
    checkOutput("p3_r6", {24'd0, regs[6]}, 32'd7);
    repeat (5) @(negedge clk);
    checkOutput("p3_haltHeld", {31'd0, halted}, 32'd1);
    checkOutput("p3_pcHeld", {24'd0, instraddr}, 32'd2);

    // Program 4: ADD 200+100 sets carry, then JC 0x40.
    clearEnv();
    poke(8'h00, 8'h10, 8'd200);
    poke(8'h02, 8'h11, 8'd100);
    poke(8'h04, 8'h72, 8'h01);
    poke(8'h06, 8'hA0, 8'h40);
    poke(8'h08, 8'hF0, 8'h00);
    poke(8'h40, 8'h13, 8'h55);
    poke(8'h42, 8'hF0, 8'h00);
    resetDut(1'b1);
    waitHalted(100, n);
    checkOutput("br_sum", {24'd0, regs[2]}, 32'd44);
    checkOutput("br_carry", {31'd0, cfReg}, 32'd1);
`ifdef MCPU_SEQ_BRANCH_EN
    checkOutput("br_haltPc", {24'd0, instraddr}, 32'h44);
    checkOutput("br_r3", {24'd0, regs[3]}, 32'h55);
    checkOutput("br_haltCycles", n, 32'd22);
`else
    checkOutput("br_haltPc", {24'd0, instraddr}, 32'h0A);
    checkOutput("br_r3", {24'd0, regs[3]}, 32'h00);
    checkOutput("br_haltCycles", n, 32'd18);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
